// File: rtl/mlp_result_streamer_if.sv
// Result stream interface for mlp_result_streamer: valid/ready beats that carry
// LANES elements, together with the row index and the sum/last markers.
interface mlp_result_streamer_if #(
    parameter int unsigned N      = 16,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned LANES  = 2
);
    localparam int unsigned RowW = (N > 1) ? $clog2(N) : 1;

    logic                      out_valid_o;
    logic                      out_ready_i;
    logic [LANES*DATA_W-1:0]   out_data_o;
    logic [RowW-1:0]           out_row_o;
    logic                      out_sum_o;
    logic                      out_last_o;

    modport master (
        output out_valid_o,
        output out_data_o,
        output out_row_o,
        output out_sum_o,
        output out_last_o,
        input  out_ready_i
    );

    modport slave (
        input  out_valid_o,
        input  out_data_o,
        input  out_row_o,
        input  out_sum_o,
        input  out_last_o,
        output out_ready_i
    );
endinterface

// File: rtl/mlp_result_streamer.sv
// Readout engine for the MLP accelerator's final activation matrix.
// Snapshots an N x N matrix of signed elements in one cycle, then streams it
// row-major, LANES elements per beat, over a valid/ready interface.
// Optional feature macro MLP_RDOUT_ROWSUM_EN: appends one row-sum beat after
// the data beats of each row.
module mlp_result_streamer #(
    parameter int unsigned N      = 16,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned LANES  = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start_i,
    input  logic [N*N*DATA_W-1:0]   mat_i,
    output logic                    busy_o,
    output logic                    done_o,
    mlp_result_streamer_if.master   out_if
);
    localparam int unsigned B    = N / LANES;
    localparam int unsigned OutW = LANES * DATA_W;
    localparam int unsigned RowW = (N > 1) ? $clog2(N) : 1;
`ifdef MLP_RDOUT_ROWSUM_EN
    localparam int unsigned BeatsPerRow = B + 1;
    localparam int unsigned SumW        = DATA_W + $clog2(N);
`else
    localparam int unsigned BeatsPerRow = B;
`endif
    localparam int unsigned BeatW = $clog2(BeatsPerRow + 1);

    localparam logic [BeatW-1:0] LastBeat = BeatW'(BeatsPerRow - 1);
    localparam logic [RowW-1:0]  LastRow  = RowW'(N - 1);

    typedef enum logic [1:0] {
        StIdle,
        StStream,
        StDone
    } state_e;

    state_e                  state_q, state_d;
    logic [N*N*DATA_W-1:0]   snap_q, snap_d;
    logic [RowW-1:0]         row_q, row_d;
    logic [BeatW-1:0]        beat_q, beat_d;

    logic                    valid;
    logic                    is_sum;
    logic                    is_last;
    logic [BeatW-1:0]        data_beat;
    logic [OutW-1:0]         lane_data;
    logic [OutW-1:0]         beat_data;

    // State, snapshot and beat/row counters; reset clears state and counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            row_q   <= '0;
            beat_q  <= '0;
            snap_q  <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            beat_q  <= beat_d;
            snap_q  <= snap_d;
        end
    end

    // Next-state: capture on start, advance only on a transfer.
    always_comb begin
        state_d = state_q;
        snap_d  = snap_q;
        row_d   = row_q;
        beat_d  = beat_q;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    snap_d  = mat_i;
                    row_d   = '0;
                    beat_d  = '0;
                    state_d = StStream;
                end
            end
            StStream: begin
                if (out_if.out_ready_i) begin
                    if (beat_q == LastBeat) begin
                        beat_d = '0;
                        if (row_q == LastRow) begin
                            state_d = StDone;
                        end else begin
                            row_d = row_q + RowW'(1);
                        end
                    end else begin
                        beat_d = beat_q + BeatW'(1);
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Lane selection from the snapshot; the sum beat index is clamped so the
    // element select never leaves the snapshot.
    always_comb begin
        int unsigned idx;
        lane_data = '0;
        data_beat = (beat_q < BeatW'(B)) ? beat_q : '0;
        for (int unsigned l = 0; l < LANES; l++) begin
            idx = 32'(row_q) * N + 32'(data_beat) * LANES + l;
            lane_data[l*DATA_W +: DATA_W] = snap_q[idx*DATA_W +: DATA_W];
        end
    end

`ifdef MLP_RDOUT_ROWSUM_EN
    logic signed [SumW-1:0] row_sum;
    logic [OutW-1:0]        sum_ext;

    // Full-precision signed sum of the current row, sign-extended to a beat.
    always_comb begin
        int unsigned idx;
        row_sum = '0;
        for (int unsigned c = 0; c < N; c++) begin
            idx     = 32'(row_q) * N + c;
            row_sum = row_sum + SumW'($signed(snap_q[idx*DATA_W +: DATA_W]));
        end
        sum_ext = OutW'(row_sum);
    end

    assign is_sum    = (beat_q == BeatW'(B));
    assign beat_data = is_sum ? sum_ext : lane_data;
`else
    assign is_sum    = 1'b0;
    assign beat_data = lane_data;
`endif

    // Outputs decoded from registered state only; zeroed outside STREAM.
    always_comb begin
        valid   = (state_q == StStream);
        is_last = valid && (row_q == LastRow) && (beat_q == LastBeat);
        out_if.out_valid_o = valid;
        out_if.out_data_o  = valid ? beat_data : '0;
        out_if.out_row_o   = valid ? row_q : '0;
        out_if.out_sum_o   = valid && is_sum;
        out_if.out_last_o  = is_last;
        busy_o             = valid;
        done_o             = (state_q == StDone);
    end
endmodule

// File: tb/tb_mlp_result_streamer.sv
// Randomized self-checking bench for mlp_result_streamer: a queue of expected
// beats is built from the matrix and compared beat by beat under random ready.
module tb_mlp_result_streamer;
    localparam int N     = 16;
    localparam int DW    = 16;
    localparam int LANES = 2;
    localparam int B     = N / LANES;
    localparam int OW    = LANES * DW;
`ifdef MLP_RDOUT_ROWSUM_EN
    localparam int BPR = B + 1;
`else
    localparam int BPR = B;
`endif
    localparam int TOTAL = N * BPR;

    typedef struct {
        logic [OW-1:0] data;
        int            row;
        bit            sum;
        bit            last;
    } beat_t;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 start_i;
    logic [N*N*DW-1:0]    mat_i;
    logic                 busy_o;
    logic                 done_o;

    mlp_result_streamer_if #(.N(N), .DATA_W(DW), .LANES(LANES)) out_if ();

    mlp_result_streamer #(.N(N), .DATA_W(DW), .LANES(LANES)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (start_i),
        .mat_i   (mat_i),
        .busy_o  (busy_o),
        .done_o  (done_o),
        .out_if  (out_if)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [DW-1:0] m [N][N];
    beat_t       exp_q [$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic fill(input int kind);
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                case (kind)
                    0:       m[r][c] = DW'(r * N + c);
                    1:       m[r][c] = DW'($urandom);
                    2:       m[r][c] = '1;
                    default: m[r][c] = 16'h7FFF;
                endcase
            end
        end
    endtask

    task automatic drive_mat();
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                mat_i[(r*N+c)*DW +: DW] = m[r][c];
    endtask

    task automatic build_model();
        exp_q.delete();
        for (int r = 0; r < N; r++) begin
            for (int k = 0; k < BPR; k++) begin
                beat_t  b;
                longint s;
                b.row  = r;
                b.sum  = (k == B);
                b.last = (r == N - 1) && (k == BPR - 1);
                b.data = '0;
                if (k < B) begin
                    for (int l = 0; l < LANES; l++)
                        b.data[l*DW +: DW] = m[r][k*LANES+l];
                end else begin
                    s = 0;
                    for (int c = 0; c < N; c++)
                        s += longint'($signed(m[r][c]));
                    b.data = OW'(s);
                end
                exp_q.push_back(b);
            end
        end
    endtask

    // mode: 0 ready always high, 1 ready 50%, 2 ready 25%.
    task automatic run_matrix(input int mode, input bit corrupt, input bit restart,
                              input int abort_at);
        int    xfers;
        int    stalls;
        int    last_it;
        bit    done_seen;
        beat_t e;
        xfers     = 0;
        stalls    = 0;
        last_it   = -1;
        done_seen = 0;
        build_model();
        drive_mat();
        @(posedge clk); #1 start_i = 1'b1;
        @(posedge clk); #1 start_i = 1'b0;
        if (corrupt) begin
            for (int i = 0; i < N * N; i++) mat_i[i*DW +: DW] = 16'h7FFF;
        end
        for (int it = 0; it < 4000; it++) begin
            case (mode)
                0:       out_if.out_ready_i = 1'b1;
                1:       out_if.out_ready_i = 1'($urandom % 2);
                default: out_if.out_ready_i = (($urandom % 4) == 0);
            endcase
            start_i = restart && (it == 20);
            @(negedge clk);
            if (done_o) begin
                check("done_after_last", 64'(it), 64'(last_it + 1));
                check("done_busy", 64'(busy_o), 64'(0));
                check("done_valid", 64'(out_if.out_valid_o), 64'(0));
                check("beat_count", 64'(xfers), 64'(TOTAL));
                check("latency", 64'(it), 64'(xfers + stalls));
                done_seen = 1;
                break;
            end
            if (out_if.out_valid_o) begin
                if (exp_q.size() == 0) begin
                    check("extra_beat", 64'(1), 64'(0));
                end else begin
                    e = exp_q[0];
                    check("data", 64'(out_if.out_data_o), 64'(e.data));
                    check("row", 64'(out_if.out_row_o), 64'(e.row));
                    check("sum", 64'(out_if.out_sum_o), 64'(e.sum));
                    check("last", 64'(out_if.out_last_o), 64'(e.last));
                    check("busy", 64'(busy_o), 64'(1));
                end
                if (out_if.out_ready_i) begin
                    if (exp_q.size() != 0) void'(exp_q.pop_front());
                    xfers++;
                    last_it = it;
                    if (abort_at > 0 && xfers == abort_at) begin
                        @(posedge clk); #1 rst_n = 1'b0;
                        start_i = 1'b0;
                        @(posedge clk);
                        @(negedge clk);
                        check("abort_valid", 64'(out_if.out_valid_o), 64'(0));
                        check("abort_busy", 64'(busy_o), 64'(0));
                        check("abort_done", 64'(done_o), 64'(0));
                        @(posedge clk); #1 rst_n = 1'b1;
                        return;
                    end
                end else begin
                    stalls++;
                end
            end else begin
                check("valid_drop", 64'(out_if.out_valid_o), 64'(1));
            end
            @(posedge clk); #1;
        end
        if (!done_seen) check("timeout", 64'(0), 64'(1));
        @(posedge clk); #1;
        start_i = 1'b0;
        out_if.out_ready_i = 1'b0;
        @(negedge clk);
        check("done_pulse", 64'(done_o), 64'(0));
        check("idle_valid", 64'(out_if.out_valid_o), 64'(0));
    endtask

    initial begin
        rst_n = 1'b0;
        start_i = 1'b0;
        mat_i = '0;
        out_if.out_ready_i = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("rst_valid", 64'(out_if.out_valid_o), 64'(0));
        check("rst_busy", 64'(busy_o), 64'(0));
        check("rst_done", 64'(done_o), 64'(0));
        check("rst_data", 64'(out_if.out_data_o), 64'(0));
        check("rst_row", 64'(out_if.out_row_o), 64'(0));
        check("rst_sum", 64'(out_if.out_sum_o), 64'(0));
        check("rst_last", 64'(out_if.out_last_o), 64'(0));
        @(posedge clk); #1 rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle_no_valid", 64'(out_if.out_valid_o), 64'(0));
        end

        fill(0); run_matrix(0, 1'b0, 1'b0, 0);
        fill(1); run_matrix(1, 1'b0, 1'b0, 0);
        fill(1); run_matrix(2, 1'b0, 1'b0, 0);
        fill(1); run_matrix(1, 1'b1, 1'b1, 0);
        fill(1); run_matrix(0, 1'b0, 1'b0, 40);
        fill(0); run_matrix(1, 1'b0, 1'b0, 0);
        fill(2); run_matrix(0, 1'b0, 1'b0, 0);
        fill(3); run_matrix(1, 1'b0, 1'b0, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/mlp_result_streamer.md
# mlp_result_streamer

Parametrised readout engine for the MLP accelerator's final activation matrix. It snapshots an N×N matrix of signed results from the compute array in one cycle. It then streams the matrix row-major, LANES elements per beat, over a valid/ready interface with full backpressure. It sits between the accelerator's output register file and the host result port, replacing the fixed 16×16, 2-lane, no-backpressure readout.

## Interface
- N, 16, matrix dimension (rows = cols); N % LANES == 0 required
- DATA_W, 16, signed element width
- LANES, 2, elements per output beat; LANES*DATA_W >= DATA_W+$clog2(N) required
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- start_i  in  1  request snapshot+stream; honoured only in IDLE
- mat_i  in  N*N*DATA_W  element (r,c) at bits [(r*N+c)*DATA_W +: DATA_W]
- busy_o  out  1  high from accepted start until final beat accepted
- out_valid_o  out  1  beat available
- out_ready_i  in  1  sink accepts beat
- out_data_o  out  LANES*DATA_W  beat payload; lane l in bits [l*DATA_W +: DATA_W]
- out_row_o  out  $clog2(N)  row index of current beat
- out_sum_o  out  1  current beat is a row-sum beat (always 0 when feature compiled out)
- out_last_o  out  1  current beat is final beat of the matrix
- done_o  out  1  one-cycle pulse after final beat accepted

## Operation
- States: IDLE, STREAM, DONE. Reset → IDLE; all outputs 0, counters 0.
- IDLE: start_i=1 → capture mat_i into internal snapshot register, row=0, beat=0 → STREAM. mat_i is ignored after capture.
- STREAM: out_valid_o=1. Data beat k of row r carries cols k*LANES … k*LANES+LANES-1, with lane 0 = lowest column.
- Transfer occurs when out_valid_o && out_ready_i. Only a transfer advances beat, row and state.
- B = N/LANES data beats per row. The beat counter wraps to 0 at B (or at B+1 with row-sum) and increments row.
- Transfer of the final beat (row N-1, last beat) → DONE.
- DONE: one cycle; done_o=1, busy_o=0, out_valid_o=0 → IDLE.
- start_i while busy_o=1 or in DONE is ignored; it is not queued.
- While out_valid_o && !out_ready_i, out_data_o, out_row_o, out_sum_o and out_last_o are held stable.
- Reset asserted mid-stream: next edge → IDLE. The stream is aborted, no done_o, and the snapshot contents are don't-care.

## Timing
- start_i sampled high at edge t (IDLE) → out_valid_o high after edge t; the first beat is transferable at edge t+1.
- With out_ready_i held 1: one beat per cycle. The final transfer is at edge t+N*B (t+N*(B+1) with row-sum). done_o is high for the cycle after it, and busy_o falls in that same cycle.
- Each low cycle of out_ready_i adds exactly one cycle of latency.
- Earliest re-start: start_i sampled in the cycle after done_o (IDLE). There are 2 idle edges between matrices.
- Outputs are registered or decoded from registered state only. There is no combinational path from out_ready_i to out_valid_o.

## Configuration
- MLP_RDOUT_ROWSUM_EN defined: after the B data beats of each row, one extra beat is sent with out_sum_o=1.
  - Its out_data_o is the signed sum of the row's N snapshot elements, computed at DATA_W+$clog2(N) bits (no overflow) and sign-extended to LANES*DATA_W.
  - out_last_o marks the row-sum beat of row N-1.
- Undefined: no sum beats, out_sum_o tied 0, no sum adder logic synthesised.

## Test plan
- Reset/idle: hold rst_n=0 for 5 cycles, then release → all outputs 0, busy_o=0; start_i=0 for 10 cycles → no valid.
- Default params, ready=1, mat(r,c)=r*16+c: beat 0 = 0x0001_0000, beat 8 = 0x0011_0010 with row=1; out_last_o only on beat 127 (0x00FF_00FE); done_o exactly 1 cycle after the final transfer.
- Backpressure: ready toggles 1,0,0,1 pseudo-randomly → payload stable while stalled, no beat lost or duplicated; scoreboard matches all 256 elements.
- Snapshot isolation: change mat_i to all 0x7FFF one cycle after start → streamed data equals the original matrix. A second start_i mid-stream is ignored, giving exactly 128 beats.
- Reset mid-stream: rst_n=0 after beat 40 → next cycle out_valid_o=0, busy_o=0, no done_o; a new start then streams from row 0.
- MLP_RDOUT_ROWSUM_EN, all elements −1 (0xFFFF): every 9th beat has out_sum_o=1 and data 0xFFFF_FFF0 (−16); 144 beats total. Repeat with all 0x7FFF → sum 0x0007_FFF0.
